leb128_fetch: RTL and testbench

Bus-initiator block for the WASM loader. It walks the byte-wide ROM read interface, fetches one unsigned LEB128 (u32) field starting at a given address, and returns the decoded value, the encoded length and the address of the following byte. It sits between the wasm section parser and the ROM, and acts as the requesting end of the ROM `addr`/`read_en`/`data_out`/`ready` handshake.

---
 rtl/leb128_fetch_if.sv | 10 +
 rtl/leb128_fetch.sv | 132 +++++++++++++
 tb/tb_leb128_fetch.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/leb128_fetch_if.sv
// Byte-wide ROM read bus between the LEB128 fetcher (master) and the ROM (slave).
interface leb128_fetch_if;
    logic [31:0] rom_addr;
    logic        rom_read_en;
    logic [7:0]  rom_data;
    logic        rom_ready;

    modport master (output rom_addr, rom_read_en, input rom_data, rom_ready);
    modport slave  (input rom_addr, rom_read_en, output rom_data, rom_ready);
endinterface

// File: rtl/leb128_fetch.sv
// Fetches one unsigned LEB128 (u32) field from the byte-wide ROM bus and returns
// the decoded value, encoded length and the address of the following byte.
module leb128_fetch #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_BYTES = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [31:0]    start_addr,
    leb128_fetch_if.master bus,
    output logic [31:0]    value,
    output logic [2:0]     length,
    output logic [31:0]    next_addr,
    output logic           done,
    output logic           busy,
    output logic [1:0]     err
);
    localparam int            TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
    localparam logic [2:0]    LAST    = 3'(MAX_BYTES - 1);
    localparam logic [1:0]    ERR_OK  = 2'd0;
    localparam logic [1:0]    ERR_OVF = 2'd1;
    localparam logic [1:0]    ERR_TMO = 2'd2;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [31:0]   addr, addr_d;
    logic          read_en, read_en_d;
    logic [31:0]   value_d, next_addr_d;
    logic [2:0]    length_d;
    logic [1:0]    err_d;
    logic          done_d, busy_d, finish;
    logic [7:0]    b;

    assign bus.rom_addr    = addr;
    assign bus.rom_read_en = read_en;
    assign b               = bus.rom_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            addr      <= '0;
            read_en   <= 1'b0;
            value     <= '0;
            length    <= '0;
            next_addr <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= ERR_OK;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            addr      <= addr_d;
            read_en   <= read_en_d;
            value     <= value_d;
            length    <= length_d;
            next_addr <= next_addr_d;
            done      <= done_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        timer_d     = timer;
        addr_d      = addr;
        read_en_d   = read_en;
        value_d     = value;
        length_d    = length;
        next_addr_d = next_addr;
        busy_d      = busy;
        err_d       = err;
        done_d      = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_d    = start_addr;
                    read_en_d = 1'b1;
                    value_d   = '0;
                    length_d  = '0;
                    err_d     = ERR_OK;
                    timer_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.rom_ready) begin
                    case (length)
                        3'd0:    value_d[6:0]   = b[6:0];
                        3'd1:    value_d[13:7]  = b[6:0];
                        3'd2:    value_d[20:14] = b[6:0];
                        3'd3:    value_d[27:21] = b[6:0];
                        default: value_d[31:28] = b[3:0];
                    endcase
                    length_d    = length + 3'd1;
                    next_addr_d = addr + 32'd1;
                    timer_d     = '0;
                    // b[7] set on the last byte also lands here: continuation past u32
                    if (length == LAST && b[7:4] != 4'd0) begin
                        err_d  = ERR_OVF;
                        finish = 1'b1;
                    end else if (!b[7]) begin
                        err_d  = ERR_OK;
                        finish = 1'b1;
                    end else begin
                        addr_d = addr + 32'd1;
                    end
                end else if (timer == TMAX) begin
                    err_d       = ERR_TMO;
                    next_addr_d = addr;
                    finish      = 1'b1;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            read_en_d = 1'b0;
            state_d   = IDLE;
        end
    end
endmodule

// File: tb/tb_leb128_fetch.sv
// Scoreboard bench for leb128_fetch with a ROM model that answers only on address change.
module tb_leb128_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [31:0] value, next_addr;
    logic [2:0]  length;
    logic        done, busy;
    logic [1:0]  err;

    leb128_fetch_if bus();

    leb128_fetch #(.TIMEOUT(16), .MAX_BYTES(5)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .bus(bus.master), .value(value), .length(length), .next_addr(next_addr),
        .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [2:0]  length;
        logic [31:0] next_addr;
        logic [1:0]  err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_cnt = 0;
    logic [7:0]  mem [256];
    logic [31:0] last_addr = '0;
    logic        last_vld = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rom_ready) rdy_cnt <= rdy_cnt + 1;
    end

    // ROM model: one-cycle ready pulse, only when the requested address differs from the last one served
    always @(posedge clk) begin
        if (rst) begin
            bus.rom_ready <= 1'b0;
        end else if (bus.rom_read_en && !bus.rom_ready && (!last_vld || bus.rom_addr != last_addr)) begin
            bus.rom_ready <= 1'b1;
            bus.rom_data  <= mem[bus.rom_addr[7:0]];
            last_addr     <= bus.rom_addr;
            last_vld      <= 1'b1;
        end else begin
            bus.rom_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("value", value, e.value);
                chk("length", 32'(length), 32'(e.length));
                chk("next_addr", next_addr, e.next_addr);
                chk("err", 32'(err), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Call at a negedge; start is sampled at the following posedge.
    task automatic start_fetch(input logic [31:0] a, input bit push, input logic [31:0] v,
                               input logic [2:0] l, input logic [31:0] na, input logic [1:0] e,
                               input int lat);
        exp_t x;
        start      = 1'b1;
        start_addr = a;
        if (push) begin
            x.value = v; x.length = l; x.next_addr = na; x.err = e; x.cyc = cyc + 1 + lat;
            sb.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy || sb.size() != 0); i++) @(negedge clk);
        chk("idle_reached", 32'(busy || sb.size() != 0), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int r0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h05;
        mem[8'h20] = 8'hE5; mem[8'h21] = 8'h8E; mem[8'h22] = 8'h26;
        for (int i = 0; i < 4; i++) begin
            mem[8'h30 + i] = 8'hFF; mem[8'h40 + i] = 8'hFF; mem[8'h50 + i] = 8'hFF;
        end
        mem[8'h34] = 8'h0F; mem[8'h44] = 8'h1F; mem[8'h54] = 8'hFF;
        mem[8'hFF] = 8'h80; mem[8'h00] = 8'h01;

        repeat (3) @(negedge clk);
        chk("rst_rom_addr", bus.rom_addr, 32'd0);
        chk("rst_read_en", 32'(bus.rom_read_en), 32'd0);
        chk("rst_value", value, 32'd0);
        chk("rst_length", 32'(length), 32'd0);
        chk("rst_next_addr", next_addr, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        start_fetch(32'h10, 1, 32'd5, 3'd1, 32'h11, 2'd0, 2);
        wait_idle();

        r0 = rdy_cnt;
        start_fetch(32'h20, 1, 32'h00098765, 3'd3, 32'h23, 2'd0, 6);
        wait_idle();
        chk("ready_pulses_3b", 32'(rdy_cnt - r0), 32'd3);

        start_fetch(32'h30, 1, 32'hFFFFFFFF, 3'd5, 32'h35, 2'd0, 10);
        wait_idle();
        start_fetch(32'h40, 1, 32'hFFFFFFFF, 3'd5, 32'h45, 2'd1, 10);
        wait_idle();
        r0 = rdy_cnt;
        start_fetch(32'h50, 1, 32'hFFFFFFFF, 3'd5, 32'h55, 2'd1, 10);
        wait_idle();
        repeat (4) @(negedge clk);
        chk("no_sixth_read", 32'(rdy_cnt - r0), 32'd5);
        chk("read_en_after_ovf", 32'(bus.rom_read_en), 32'd0);

        // Same address twice: the ROM stays silent the second time
        start_fetch(32'h10, 1, 32'd5, 3'd1, 32'h11, 2'd0, 2);
        wait_idle();
        start_fetch(32'h10, 1, 32'd0, 3'd0, 32'h10, 2'd2, 16);
        wait_idle();
        chk("read_en_after_tmo", 32'(bus.rom_read_en), 32'd0);

        start_fetch(32'hFFFFFFFF, 1, 32'h80, 3'd2, 32'h1, 2'd0, 4);
        wait_idle();

        start_fetch(32'h20, 1, 32'h0, 3'd0, 32'h0, 2'd0, 6);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_read_en", 32'(bus.rom_read_en), 32'd0);
        chk("midrst_value", value, 32'd0);
        repeat (8) @(negedge clk);
        start_fetch(32'h10, 1, 32'd5, 3'd1, 32'h11, 2'd0, 2);
        wait_idle();

        start_fetch(32'h20, 1, 32'h00098765, 3'd3, 32'h23, 2'd0, 6);
        @(negedge clk);
        start_fetch(32'h10, 0, 32'd0, 3'd0, 32'd0, 2'd0, 0);
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        chk("done_seen", 32'(done), 32'd1);
        start_fetch(32'h10, 1, 32'd5, 3'd1, 32'h11, 2'd0, 2);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
